// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake and feeds IF/ID.
// Optional fetch watchdog is compiled in by defining IF_FETCH_TIMEOUT_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instruccion_out,
  output logic [31:0] pc4_out,
  output logic        valid_out,
  output logic        flush_out,
  output logic        fetch_err
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_d, instr_d, pc4_d;
  logic            kill_q, kill_d;
  logic            req_d, valid_d, flush_d, err_d;
  logic            redirect, ack_ok, timeout;
  logic [XLEN-1:0] target, pc_plus4;

  // Branch from EX is older than a jump from ID, so it wins.
  assign redirect = branch_taken | jump;
  assign target   = (branch_taken ? branch_target : jump_target) & ~XLEN'(3);
  assign ack_ok   = imem_ack & imem_req;
  assign pc_plus4 = pc_q + XLEN'(4);

`ifdef IF_FETCH_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_q;

  // Cycles the current request has been outstanding; saturates one below the limit.
  always_ff @(posedge clk) begin
    if (reset || !imem_req || ack_ok) begin
      wait_q <= '0;
    end else if (wait_q != CW'(TIMEOUT_CYCLES - 1)) begin
      wait_q <= wait_q + CW'(1);
    end
  end

  assign timeout = imem_req & ~imem_ack & (wait_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      kill_q          <= 1'b0;
      imem_req        <= 1'b0;
      imem_addr       <= '0;
      instruccion_out <= '0;
      pc4_out         <= '0;
      valid_out       <= 1'b0;
      flush_out       <= 1'b0;
      fetch_err       <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      kill_q          <= kill_d;
      imem_req        <= req_d;
      imem_addr       <= addr_d;
      instruccion_out <= instr_d;
      pc4_out         <= pc4_d;
      valid_out       <= valid_d;
      flush_out       <= flush_d;
      fetch_err       <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    req_d   = imem_req;
    addr_d  = imem_addr;
    instr_d = instruccion_out;
    pc4_d   = pc4_out;
    valid_d = valid_out;
    flush_d = redirect;
    err_d   = fetch_err;

    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d = target;
        end
        req_d   = 1'b1;
        addr_d  = redirect ? target : pc_q;
        state_d = REQ;
      end

      REQ: begin
        if (ack_ok) begin
          kill_d = 1'b0;
          if (redirect) begin
            pc_d   = target;
            addr_d = target;
          end else if (kill_q) begin
            // Stale data for a redirected fetch: drop it and fetch the new PC.
            addr_d = pc_q;
          end else begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            req_d   = 1'b0;
            state_d = HOLD;
          end
        end else if (redirect) begin
          pc_d   = target;
          kill_d = 1'b1;
        end else if (timeout) begin
          err_d   = 1'b1;
          kill_d  = 1'b0;
          instr_d = '0;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (redirect || !stall) begin
          pc_d    = redirect ? target : pc_plus4;
          addr_d  = redirect ? target : pc_plus4;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction fetch stage that drives the IF/ID pipeline register. It owns the PC and issues word fetches to instruction memory over a req/ack handshake. It presents instruction and PC+4 with a valid flag to IF/ID, and redirects on branch or jump. It also emits the flush pulse that IF/ID uses as its clear input.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
TIMEOUT_CYCLES, 16, watchdog limit on an outstanding fetch (used only with optional feature)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit holds IF/ID; current instruction not consumed
branch_taken  input  1  one-cycle redirect request from EX
branch_target  input  32  branch destination
jump  input  1  one-cycle redirect request from ID
jump_target  input  32  jump destination
imem_req  output  1  fetch request, registered
imem_addr  output  32  fetch word address, registered; stable while imem_req=1
imem_rdata  input  32  instruction word; valid when imem_ack=1
imem_ack  input  1  one-cycle fetch completion
instruccion_out  output  32  fetched instruction to IF/ID
pc4_out  output  32  address of fetched instruction + 4
valid_out  output  1  instruccion_out/pc4_out valid; drives IF/ID enable
flush_out  output  1  one-cycle pulse on redirect; drives IF/ID clear
fetch_err  output  1  sticky timeout flag (tied 0 without optional feature)

Behaviour:
- Reset: pc=RESET_PC, state=IDLE, kill=0.
- All outputs are 0 on reset: imem_req, imem_addr, instruccion_out, pc4_out, valid_out, flush_out, fetch_err.
- Reset mid-fetch: imem_req drops at the next edge. A late ack is ignored.
- IDLE: on the first edge with reset low, go to REQ with imem_req=1 and imem_addr=pc.
- REQ: hold imem_req and imem_addr until imem_ack. Ignore imem_ack whenever imem_req=0. Only one request may be outstanding.
  - On ack with kill=0: instruccion_out=imem_rdata, pc4_out=pc+4, valid_out=1, imem_req=0, go to HOLD.
  - On ack with kill=1: discard the data, clear kill, set imem_addr=pc (the redirected PC), stay in REQ with imem_req=1.
- HOLD: outputs stay stable while stall=1.
  - Consume event is valid_out=1 and stall=0 at an edge.
  - On consume: pc=pc+4, valid_out=0, go to REQ fetching the new pc.
  - Minimum latency is 1 cycle from req to ack, giving 1 instruction per 2 cycles at best.
- Redirect:
  - Redirect is branch_taken or jump. branch_taken has priority when both are asserted (it is the older instruction).
  - Target bits [1:0] are forced to 00.
  - On the redirect edge: pc=target and flush_out=1 for exactly one cycle.
  - In HOLD: valid_out=0, go to REQ at the target next cycle.
  - In REQ before ack: set kill, wait for ack.
  - Redirect on the same edge as ack: the ack data is discarded (no valid_out) and REQ re-issues at the target next cycle.
  - In IDLE: only pc is updated.
  - Redirect overrides stall.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Back-to-back redirects: the last one wins. kill stays set until the outstanding ack arrives.

Optional Feature:
Macro IF_FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs while imem_req=1 and clears on ack or reset.
  - When the counter reaches TIMEOUT_CYCLES without an ack: fetch_err=1 (sticky until reset), instruccion_out=32'h0000_0000 (NOP), pc4_out=pc+4, valid_out=1, go to HOLD.
  - The late ack is then ignored.
- Undefined: no counter; fetch_err tied 0; REQ waits indefinitely.

Test Plan:
- Reset release, memory acks 1 cycle after each req, stall=0 -> addresses 0x0,0x4,0x8 in order; pc4_out 0x4,0x8,0xC; valid_out pulses; flush_out=0.
- Ack with rdata=0x8C010004 while stall=1 for 3 cycles -> instruccion_out/valid_out held 3 cycles; next imem_addr=pc+4 only after stall falls.
- branch_taken=1 with target 0x0000_0103 while request to 0x10 outstanding, ack 2 cycles later -> flush_out one pulse; 0x10 data discarded (valid_out stays 0); next imem_addr=0x100.
- branch_taken and jump asserted the same cycle (targets 0x200/0x300) -> pc=0x200; single flush_out pulse.
- RESET_PC=0xFFFF_FFFC, one fetch consumed -> pc4_out=0x0 and next imem_addr=0x0.
- Reset asserted mid-request, then ack arrives -> imem_req=0 the cycle after reset; ack ignored; fetch restarts at RESET_PC. With IF_FETCH_TIMEOUT_EN defined and no ack for 16 cycles -> fetch_err=1, valid_out=1, instruccion_out=0.
